pipeline_hazard_ctrl: RTL and testbench

//  Sequences the 5-stage tiny MIPS pipeline (IF/ID/EX/MEM/WB) around RAW hazards and control transfers.

---
 rtl/pipeline_hazard_ctrl.sv | 154 +++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and redirect sequencer for the 5-stage pipeline: stalls ID on RAW hazards, flushes IF/ID
// after taken branches/jumps. Define FORWARD_EN when EX/MEM forwarding exists (load-use stalls only).
module pipeline_hazard_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic [4:0]       id_rd,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             ex_branch_taken,
    input  logic             ex_jump,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_bubble,
    output logic             if_id_flush,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [1:0] RemInit = 2'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StStall = 2'd1,
        StFlush = 2'd2
    } state_e;

    typedef struct packed {
        logic       regwrite;
        logic       memread;
        logic [4:0] rd;
    } slot_t;

    state_e           state_q, state_d;
    logic [1:0]       rem_q, rem_d;
    slot_t            ex_q, mem_q, wb_q, ex_d;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
    logic             redirect, stall_req, haz_ex;

    function automatic logic hazard(input logic       rw,
                                    input logic [4:0] rd,
                                    input logic       valid,
                                    input logic [4:0] rs,
                                    input logic [4:0] rt,
                                    input logic       uses_rt);
        return valid & rw & (rd != 5'd0) & ((rd == rs) | (uses_rt & (rd == rt)));
    endfunction

    assign redirect = ex_branch_taken | ex_jump;
    assign haz_ex   = hazard(ex_q.regwrite, ex_q.rd, id_valid, id_rs, id_rt, id_uses_rt);

`ifdef FORWARD_EN
    assign stall_req = haz_ex & ex_q.memread;
`else
    logic haz_mem, haz_wb;
    assign haz_mem   = hazard(mem_q.regwrite, mem_q.rd, id_valid, id_rs, id_rt, id_uses_rt);
    // Register file writes at the clock edge, so the WB producer is still in flight.
    assign haz_wb    = hazard(wb_q.regwrite, wb_q.rd, id_valid, id_rs, id_rt, id_uses_rt);
    assign stall_req = haz_ex | haz_mem | haz_wb;
`endif

    // Oldest shadow slot only feeds hazard detection, never another slot.
    logic unused_wb;
    assign unused_wb = ^wb_q;

    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_bubble = 1'b0;
        if_id_flush  = 1'b0;
        state_d      = state_q;
        rem_d        = rem_q;
        if (!rst) begin
            case (state_q)
                StRun, StStall: begin
                    if (redirect) begin
                        if_id_flush  = 1'b1;
                        id_ex_bubble = 1'b1;
                        rem_d        = RemInit;
                        state_d      = (RemInit != 2'd0) ? StFlush : StRun;
                    end else if (stall_req) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_bubble = 1'b1;
                        state_d      = StStall;
                    end else begin
                        state_d = StRun;
                    end
                end
                StFlush: begin
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                    if (redirect) begin
                        rem_d   = RemInit;
                        state_d = (RemInit != 2'd0) ? StFlush : StRun;
                    end else begin
                        rem_d   = rem_q - 2'd1;
                        state_d = (rem_q <= 2'd1) ? StRun : StFlush;
                    end
                end
                default: begin
                    rem_d   = 2'd0;
                    state_d = StRun;
                end
            endcase
        end
    end

    always_comb begin
        ex_d = '0;
        if (id_valid && !id_ex_bubble) begin
            ex_d.regwrite = id_regwrite;
            ex_d.memread  = id_memread;
            ex_d.rd       = id_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StRun;
            rem_q       <= 2'd0;
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            // Shadow advances every cycle; stalls inject a bubble into EX.
            ex_q    <= ex_d;
            mem_q   <= ex_q;
            wb_q    <= mem_q;
            if (!pc_write && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (redirect && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign state       = state_q;
    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomised and directed bench for pipeline_hazard_ctrl against an issue-history reference model.
module tb_pipeline_hazard_ctrl;

    localparam int CW  = 4;
    localparam int FC  = 2;
    localparam int SAT = (1 << CW) - 1;
`ifdef FORWARD_EN
    localparam int EXP_ADD = 0;
    localparam int EXP_LW  = 1;
`else
    localparam int EXP_ADD = 3;
    localparam int EXP_LW  = 3;
`endif

    logic          clk, rst;
    logic          id_valid, id_uses_rt, id_regwrite, id_memread;
    logic [4:0]    id_rs, id_rt, id_rd;
    logic          ex_branch_taken, ex_jump;
    logic          pc_write, if_id_write, id_ex_bubble, if_id_flush;
    logic [1:0]    state;
    logic [CW-1:0] stall_count, flush_count;

    pipeline_hazard_ctrl #(
        .FLUSH_CYCLES(FC),
        .CNT_W       (CW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .id_valid       (id_valid),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_uses_rt     (id_uses_rt),
        .id_rd          (id_rd),
        .id_regwrite    (id_regwrite),
        .id_memread     (id_memread),
        .ex_branch_taken(ex_branch_taken),
        .ex_jump        (ex_jump),
        .pc_write       (pc_write),
        .if_id_write    (if_id_write),
        .id_ex_bubble   (id_ex_bubble),
        .if_id_flush    (if_id_flush),
        .state          (state),
        .stall_count    (stall_count),
        .flush_count    (flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the last three issue decisions (index 0 = youngest, now in EX).
    int m_rw[3], m_mr[3], m_rd[3];
    int m_rem, m_state, m_sc, m_fc;

    function automatic bit m_haz(input int i);
        return m_rw[i] != 0 && m_rd[i] != 0 && id_valid &&
               (m_rd[i] == int'(id_rs) || (id_uses_rt && m_rd[i] == int'(id_rt)));
    endfunction

    function automatic bit m_stall();
`ifdef FORWARD_EN
        return m_haz(0) && m_mr[0] != 0;
`else
        return m_haz(0) || m_haz(1) || m_haz(2);
`endif
    endfunction

    task automatic m_outs(output bit pcw, output bit ifw, output bit bub, output bit fl);
        pcw = 1; ifw = 1; bub = 0; fl = 0;
        if (!rst) begin
            if (ex_branch_taken || ex_jump || m_rem > 0) begin
                bub = 1; fl = 1;
            end else if (m_stall()) begin
                pcw = 0; ifw = 0; bub = 1;
            end
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < 3; i++) begin
            m_rw[i] = 0; m_mr[i] = 0; m_rd[i] = 0;
        end
        m_rem = 0; m_state = 0; m_sc = 0; m_fc = 0;
    endtask

    // Compare, then advance the model by one cycle.
    initial begin
        bit pcw, ifw, bub, fl, redir, stl;
        m_reset();
        forever begin
            @(negedge clk);
            m_outs(pcw, ifw, bub, fl);
            if (cmp_en) begin
                check("pc_write", pc_write, pcw);
                check("if_id_write", if_id_write, ifw);
                check("id_ex_bubble", id_ex_bubble, bub);
                check("if_id_flush", if_id_flush, fl);
                check("state", state, m_state);
                check("stall_count", stall_count, m_sc);
                check("flush_count", flush_count, m_fc);
            end
            if (rst) begin
                m_reset();
            end else begin
                redir = ex_branch_taken || ex_jump;
                stl   = m_stall();
                if (!pcw && m_sc < SAT) m_sc++;
                if (redir && m_fc < SAT) m_fc++;
                for (int i = 2; i > 0; i--) begin
                    m_rw[i] = m_rw[i-1]; m_mr[i] = m_mr[i-1]; m_rd[i] = m_rd[i-1];
                end
                if (id_valid && !bub) begin
                    m_rw[0] = int'(id_regwrite); m_mr[0] = int'(id_memread); m_rd[0] = int'(id_rd);
                end else begin
                    m_rw[0] = 0; m_mr[0] = 0; m_rd[0] = 0;
                end
                if (redir) begin
                    m_rem   = FC - 1;
                    m_state = (m_rem > 0) ? 2 : 0;
                end else if (m_rem > 0) begin
                    m_rem--;
                    m_state = (m_rem > 0) ? 2 : 0;
                end else begin
                    m_state = stl ? 1 : 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0; id_rd = 0;
        id_regwrite = 0; id_memread = 0; ex_branch_taken = 0; ex_jump = 0;
    endtask

    task automatic set_id(input bit v, input int rs, input int rt, input bit ur, input int rd,
                          input bit rw, input bit mr);
        id_valid = v; id_rs = 5'(rs); id_rt = 5'(rt); id_uses_rt = ur; id_rd = 5'(rd);
        id_regwrite = rw; id_memread = mr;
    endtask

    task automatic do_reset();
        rst = 1;
        idle();
        tick();
        tick();
        rst = 0;
    endtask

    initial begin
        int nst, nbub, nfl;
        rst = 1;
        idle();
        tick();
        cmp_en = 1;
        #3;
        check("reset_state", state, 0);
        check("reset_stall_count", stall_count, 0);
        check("reset_flush_count", flush_count, 0);
        check("reset_pc_write", pc_write, 1);
        check("reset_if_id_flush", if_id_flush, 0);
        tick();
        rst = 0;

        // add $3,$1,$2 ; add $4,$3,$1
        do_reset();
        set_id(1, 1, 2, 1, 3, 1, 0);
        tick();
        nst = 0;
        for (int i = 0; i < 4; i++) begin
            set_id(1, 3, 1, 1, 4, 1, 0);
            #3;
            if (pc_write === 1'b0) nst++;
            if (i == 1) check("add_pair_state", state, (EXP_ADD > 0) ? 1 : 0);
            tick();
        end
        check("add_pair_stall_cycles", nst, EXP_ADD);
        idle();
        #3;
        check("add_pair_stall_count", stall_count, EXP_ADD);
        tick();

        // lw $5,0($0) ; add $6,$5,$1
        do_reset();
        set_id(1, 0, 0, 0, 5, 1, 1);
        tick();
        nst = 0; nbub = 0;
        for (int i = 0; i < 4; i++) begin
            set_id(1, 5, 1, 1, 6, 1, 0);
            #3;
            if (pc_write === 1'b0) nst++;
            if (id_ex_bubble === 1'b1) nbub++;
            tick();
        end
        check("load_use_stalls", nst, EXP_LW);
        check("load_use_bubbles", nbub, EXP_LW);
        idle();

        // Taken branch resolved in EX
        do_reset();
        nfl = 0;
        set_id(1, 7, 8, 1, 9, 1, 0);
        ex_branch_taken = 1;
        #3;
        if (if_id_flush === 1'b1) nfl++;
        check("branch_pc_write", pc_write, 1);
        tick();
        idle();
        #3;
        if (if_id_flush === 1'b1) nfl++;
        check("branch_state_flush", state, 2);
        tick();
        #3;
        if (if_id_flush === 1'b1) nfl++;
        check("branch_state_run", state, 0);
        check("branch_flush_cycles", nfl, FC);
        check("branch_flush_count", flush_count, 1);
        tick();

        // Branch arriving while stalled
        do_reset();
        set_id(1, 0, 0, 0, 5, 1, 1);
        tick();
        set_id(1, 5, 1, 1, 6, 1, 0);
        tick();
        ex_branch_taken = 1;
        #3;
        check("stall_then_branch_state", state, 1);
        check("stall_then_branch_pc_write", pc_write, 1);
        check("stall_then_branch_flush", if_id_flush, 1);
        tick();
        idle();
        #3;
        check("stall_then_branch_next", state, 2);
        tick();

        // $0 never creates a hazard
        do_reset();
        set_id(1, 1, 2, 1, 0, 1, 0);
        tick();
        set_id(1, 0, 0, 0, 0, 1, 1);
        tick();
        nst = 0;
        for (int i = 0; i < 4; i++) begin
            set_id(1, 0, 0, 1, 5, 1, 0);
            #3;
            if (pc_write === 1'b0) nst++;
            tick();
        end
        check("reg0_no_stall", nst, 0);
        idle();

        // Reset in the middle of a flush discards in-flight producers
        do_reset();
        set_id(1, 1, 2, 1, 3, 1, 0);
        tick();
        idle();
        ex_jump = 1;
        tick();
        ex_jump = 0;
        #3;
        check("jump_state_flush", state, 2);
        rst = 1;
        #1;
        check("rst_flush_pc_write", pc_write, 1);
        check("rst_flush_if_id_write", if_id_write, 1);
        check("rst_flush_bubble", id_ex_bubble, 0);
        check("rst_flush_if_id_flush", if_id_flush, 0);
        tick();
        rst = 0;
        set_id(1, 3, 1, 1, 4, 1, 0);
        #3;
        check("after_rst_state", state, 0);
        check("after_rst_no_stall", pc_write, 1);
        check("after_rst_flush_count", flush_count, 0);
        tick();
        idle();

        // Random traffic over a small register set for frequent hazards
        for (int c = 0; c < 3000; c++) begin
            rst             = ($urandom_range(0, 199) == 0);
            id_valid        = ($urandom_range(0, 3) != 0);
            id_rs           = 5'($urandom_range(0, 3));
            id_rt           = 5'($urandom_range(0, 3));
            id_rd           = 5'($urandom_range(0, 3));
            id_uses_rt      = 1'($urandom_range(0, 1));
            id_regwrite     = ($urandom_range(0, 3) != 0);
            id_memread      = ($urandom_range(0, 2) == 0);
            ex_branch_taken = ($urandom_range(0, 11) == 0);
            ex_jump         = ($urandom_range(0, 19) == 0);
            tick();
        end
        rst = 0;
        idle();
        tick();
        tick();
        cmp_en = 0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
